// File: rtl/barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package barrel_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ASR = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_t;

  // Upper bound on operand width handled by bit_reverse.
  localparam int BR_MAX_W = 256;
  localparam int BR_IDX_W = $clog2(BR_MAX_W);

  // Reverses the low w bits of d into the low w bits of the result.
  function automatic logic [BR_MAX_W-1:0] bit_reverse(input logic [BR_MAX_W-1:0] d,
                                                      input int w);
    logic [BR_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BR_MAX_W; i++) begin
      if (i < w) r[BR_IDX_W'(i)] = d[BR_IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered right-shift stage of the barrel shifter (shift by 2**K when amt[K] is set).
// SHIFT_FLAGS_EN adds carry tracking through the stage.
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_amt,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_sign,
`ifdef SHIFT_FLAGS_EN
  input  logic             in_carry,
  output logic             carry_q,
`endif
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q,
  output logic [N-1:0]     amt_q,
  output logic [OP_W-1:0]  op_q,
  output logic             sign_q
);

  localparam int SHIFT = 2 ** K;
  localparam int ROT   = SHIFT % WIDTH;

  logic             fill;
  logic             is_rot;
  logic             do_shift;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] data_nxt;

  assign fill     = (in_op == OP_ASR) && in_sign;
  assign is_rot   = (in_op == OP_ROL) || (in_op == OP_ROR);
  assign do_shift = in_amt[K];

  // Shifts wider than the operand leave only fill bits; rotates wrap modulo WIDTH.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i + SHIFT < WIDTH) begin : g_src
      assign shr[i] = in_data[i + SHIFT];
    end else begin : g_fill
      assign shr[i] = fill;
    end
    assign rot[i] = in_data[(i + ROT) % WIDTH];
  end

  assign data_nxt = !do_shift ? in_data : (is_rot ? rot : shr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= in_valid;
      data_q  <= data_nxt;
      amt_q   <= in_amt;
      op_q    <= in_op;
      sign_q  <= in_sign;
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic shift_out;
  logic carry_nxt;

  if (SHIFT <= WIDTH) begin : g_co_in
    assign shift_out = in_data[SHIFT - 1];
  end else begin : g_co_fill
    assign shift_out = fill;
  end

  assign carry_nxt = (do_shift && !is_rot) ? shift_out : in_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (adv) begin
      carry_q <= carry_nxt;
    end
  end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-stage pipelined barrel shifter (LSL/LSR/ASR/ROL/ROR) with valid/ready handshake.
// Define SHIFT_FLAGS_EN to add the out_zero / out_carry result flags.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 2 ** N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_amt,
  input  logic [OP_W-1:0]  in_op,
`ifdef SHIFT_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic                       adv;
  logic                       entry_left;
  logic                       entry_pass;
  logic                       exit_left;
  logic                       unused_tail;
  logic [N:0]                 valid_s;
  logic [N:0]                 sign_s;
  logic [N:0][WIDTH-1:0]      data_s;
  logic [N:0][N-1:0]          amt_s;
  logic [N:0][OP_W-1:0]       op_s;

  // The whole pipe moves together; bubbles are kept rather than squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Left ops run through the right-shift stages on a bit-reversed operand.
  assign entry_left = (in_op == OP_LSL) || (in_op == OP_ROL);
  assign entry_pass = in_op > OP_ROR;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = entry_left ? WIDTH'(bit_reverse(BR_MAX_W'(in_data), WIDTH)) : in_data;
  assign amt_s[0]   = entry_pass ? '0 : in_amt;
  assign op_s[0]    = in_op;
  assign sign_s[0]  = in_data[WIDTH-1];

`ifdef SHIFT_FLAGS_EN
  logic [N:0] carry_s;
  assign carry_s[0] = 1'b0;
`endif

  for (genvar k = 0; k < N; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .N     (N),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .in_valid (valid_s[k]),
      .in_data  (data_s[k]),
      .in_amt   (amt_s[k]),
      .in_op    (op_s[k]),
      .in_sign  (sign_s[k]),
`ifdef SHIFT_FLAGS_EN
      .in_carry (carry_s[k]),
      .carry_q  (carry_s[k+1]),
`endif
      .valid_q  (valid_s[k+1]),
      .data_q   (data_s[k+1]),
      .amt_q    (amt_s[k+1]),
      .op_q     (op_s[k+1]),
      .sign_q   (sign_s[k+1])
    );
  end

  assign exit_left = (op_s[N] == OP_LSL) || (op_s[N] == OP_ROL);
  assign out_valid = valid_s[N];
  assign out_data  = exit_left ? WIDTH'(bit_reverse(BR_MAX_W'(data_s[N]), WIDTH)) : data_s[N];

  // Amount and sign are spent once the last stage has shifted.
  assign unused_tail = ^{amt_s[N], sign_s[N]};

`ifdef SHIFT_FLAGS_EN
  // Zero flag is qualified by valid so it reads 0 out of reset.
  assign out_zero  = out_valid && (data_s[N] == '0);
  assign out_carry = carry_s[N];
`endif

endmodule
